// File: rtl/logic_gate_unit_pkg.sv
// Shared op-code type and buffer constants for logic_gate_unit.
`timescale 1ns/1ps
package logic_gate_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOTA = 3'b110,
        OP_RSVD = 3'b111
    } lgu_op_e;

    localparam int unsigned LGU_DEPTH = 2;
    localparam int unsigned LGU_CNT_W = 2;

    function automatic logic lgu_is_reserved(input logic [2:0] op);
        return op == OP_RSVD;
    endfunction

endpackage

// File: rtl/lgu_skid_buf.sv
// Two-entry FIFO skid buffer; head entry drives the output directly from a register.
`timescale 1ns/1ps
module lgu_skid_buf
    import logic_gate_unit_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PAYLOAD_W-1:0] data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PAYLOAD_W-1:0] data_o
);

    logic [LGU_CNT_W-1:0] cnt_q, cnt_d;
    logic                 in_ready_q, in_ready_d;
    logic [PAYLOAD_W-1:0] head_q, head_d;
    logic [PAYLOAD_W-1:0] tail_q, tail_d;
    logic                 push, pop;

    assign out_valid_o = (cnt_q != '0);
    assign in_ready_o  = in_ready_q;
    assign data_o      = head_q;

    assign push = in_valid_i & in_ready_q;
    assign pop  = out_valid_o & out_ready_i;

    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case ({push, pop})
            2'b10: begin
                if (cnt_q == '0) head_d = data_i;
                else             tail_d = data_i;
                cnt_d = cnt_q + LGU_CNT_W'(1);
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - LGU_CNT_W'(1);
            end
            // Push and pop together only happen at count 1: the new entry replaces the head.
            2'b11: head_d = data_i;
            default: ;
        endcase
        in_ready_d = (cnt_d < LGU_CNT_W'(LGU_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

endmodule

// File: rtl/logic_gate_unit.sv
// Bitwise logic unit with a 2-entry output buffer.
// Optional macro LGU_REDUCE_EN adds buffered y_any / y_all reduction outputs.
`timescale 1ns/1ps
module logic_gate_unit
    import logic_gate_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             op_err
`ifdef LGU_REDUCE_EN
   ,output logic             y_any,
    output logic             y_all
`endif
);

`ifdef LGU_REDUCE_EN
    localparam int unsigned PAYLOAD_W = WIDTH + 3;
`else
    localparam int unsigned PAYLOAD_W = WIDTH + 1;
`endif

    logic [WIDTH-1:0]     res_y;
    logic                 res_err;
    logic [PAYLOAD_W-1:0] payload_in, payload_out;

    always_comb begin
        res_y = '0;
        case (op)
            OP_AND:  res_y = a & b;
            OP_OR:   res_y = a | b;
            OP_XOR:  res_y = a ^ b;
            OP_NAND: res_y = ~(a & b);
            OP_NOR:  res_y = ~(a | b);
            OP_XNOR: res_y = ~(a ^ b);
            OP_NOTA: res_y = ~a;
            default: res_y = '0;
        endcase
        res_err = lgu_is_reserved(op);
    end

`ifdef LGU_REDUCE_EN
    // Reductions are taken at evaluation time so they travel with their result.
    assign payload_in = {&res_y, |res_y, res_err, res_y};
    assign y_any      = payload_out[WIDTH+1];
    assign y_all      = payload_out[WIDTH+2];
`else
    assign payload_in = {res_err, res_y};
`endif

    assign y      = payload_out[WIDTH-1:0];
    assign op_err = payload_out[WIDTH];

    lgu_skid_buf #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .data_i      (payload_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .data_o      (payload_out)
    );

endmodule

// File: tb/tb_logic_gate_unit.sv
// Self-checking bench for logic_gate_unit at WIDTH 8, 1 and 32.
`timescale 1ns/1ps
module tb_logic_gate_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       iv8, ir8, ov8, or8, err8;
    logic [2:0] op8;
    logic [7:0] a8, b8, y8;
    logic       iv1, ir1, ov1, or1, err1;
    logic [2:0] op1;
    logic [0:0] a1, b1, y1;
    logic        iv32, ir32, ov32, or32, err32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, y32;
`ifdef LGU_REDUCE_EN
    logic any8, all8, any1, all1, any32, all32;
`endif

    logic_gate_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .y(y8), .op_err(err8)
`ifdef LGU_REDUCE_EN
       ,.y_any(any8), .y_all(all8)
`endif
    );

    logic_gate_unit #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .op(op1), .a(a1), .b(b1),
        .out_valid(ov1), .out_ready(or1), .y(y1), .op_err(err1)
`ifdef LGU_REDUCE_EN
       ,.y_any(any1), .y_all(all1)
`endif
    );

    logic_gate_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .op(op32), .a(a32), .b(b32),
        .out_valid(ov32), .out_ready(or32), .y(y32), .op_err(err32)
`ifdef LGU_REDUCE_EN
       ,.y_any(any32), .y_all(all32)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: per-bit truth table indexed by {a_bit, b_bit}; returns {op_err, y}.
    function automatic logic [64:0] lgu_ref(input int w, input logic [2:0] op,
                                           input logic [63:0] a, input logic [63:0] b);
        logic [3:0]  tt;
        logic [63:0] r;
        r = '0;
        case (op)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b1110;
            3'd2:    tt = 4'b0110;
            3'd3:    tt = 4'b0111;
            3'd4:    tt = 4'b0001;
            3'd5:    tt = 4'b1001;
            3'd6:    tt = 4'b0011;
            default: tt = 4'b0000;
        endcase
        for (int i = 0; i < w; i++) r[i] = tt[{a[i], b[i]}];
        return {(op == 3'b111), r};
    endfunction

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       err;
    } vec_t;
    vec_t vecs[10];

    logic [64:0] q1[$];
    logic [64:0] q32[$];
    logic [64:0] exp_r;

    task automatic idle_all();
        iv8 = 0; or8 = 0; op8 = '0; a8 = '0; b8 = '0;
        iv1 = 0; or1 = 0; op1 = '0; a1 = '0; b1 = '0;
        iv32 = 0; or32 = 0; op32 = '0; a32 = '0; b32 = '0;
    endtask

    task automatic set8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        iv8 = 1; op8 = op; a8 = a; b8 = b;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[1] = '{3'b001, 8'hF0, 8'h3C, 8'hFC, 1'b0};
        vecs[2] = '{3'b010, 8'hF0, 8'h3C, 8'hCC, 1'b0};
        vecs[3] = '{3'b011, 8'hF0, 8'h3C, 8'hCF, 1'b0};
        vecs[4] = '{3'b100, 8'hF0, 8'h3C, 8'h03, 1'b0};
        vecs[5] = '{3'b101, 8'hF0, 8'h3C, 8'h33, 1'b0};
        vecs[6] = '{3'b110, 8'hF0, 8'h3C, 8'h0F, 1'b0};
        vecs[7] = '{3'b111, 8'hFF, 8'h3C, 8'h00, 1'b1};
        vecs[8] = '{3'b000, 8'h00, 8'hFF, 8'h00, 1'b0};
        vecs[9] = '{3'b110, 8'h00, 8'h5A, 8'hFF, 1'b0};

        // Reset state
        rst_n = 1'b0;
        idle_all();
        #1;
        chk("rst_out_valid", ov8, 0);
        chk("rst_in_ready", ir8, 0);
        chk("rst_y", y8, 0);
        chk("rst_op_err", err8, 0);
        chk("rst_in_ready_w32", ir32, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_edge", ir8, 0);
        @(negedge clk);
        chk("in_ready_after_edge", ir8, 1);
        chk("in_ready_after_edge_w1", ir1, 1);

        // Table: one op per cycle, latency 1, continuous drain
        or8 = 1;
        for (int i = 0; i < 10; i++) begin
            set8(vecs[i].op, vecs[i].a, vecs[i].b);
            chk($sformatf("tbl%0d_in_ready", i), ir8, 1);
            next_cycle();
            chk($sformatf("tbl%0d_out_valid", i), ov8, 1);
            chk($sformatf("tbl%0d_y", i), y8, vecs[i].y);
            chk($sformatf("tbl%0d_op_err", i), err8, vecs[i].err);
`ifdef LGU_REDUCE_EN
            chk($sformatf("tbl%0d_y_any", i), any8, |vecs[i].y);
            chk($sformatf("tbl%0d_y_all", i), all8, &vecs[i].y);
`endif
        end
        iv8 = 0;
        next_cycle();
        chk("tbl_drained", ov8, 0);

        // Backpressure: fill to 2, third set refused, then drain in order
        or8 = 0;
        set8(3'b000, 8'hAA, 8'h0F);
        next_cycle();
        chk("bp_out_valid", ov8, 1);
        chk("bp_y0", y8, 8'h0A);
        chk("bp_in_ready_cnt1", ir8, 1);
        set8(3'b001, 8'hA0, 8'h05);
        next_cycle();
        chk("bp_in_ready_full", ir8, 0);
        chk("bp_y0_held", y8, 8'h0A);
        set8(3'b010, 8'hFF, 8'h00);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            chk("bp_in_ready_still_full", ir8, 0);
            chk("bp_y0_stable", y8, 8'h0A);
        end
        iv8 = 0; or8 = 1;
        next_cycle();
        chk("bp_out_valid_second", ov8, 1);
        chk("bp_y1", y8, 8'hA5);
        chk("bp_in_ready_reopen", ir8, 1);
        next_cycle();
        chk("bp_empty", ov8, 0);

        // Reset pulse while full
        or8 = 0;
        set8(3'b011, 8'h0F, 8'hFF);
        next_cycle();
        set8(3'b100, 8'h00, 8'h00);
        next_cycle();
        iv8 = 0;
        chk("mr_full", ir8, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", ov8, 0);
        chk("mr_in_ready", ir8, 0);
        chk("mr_y", y8, 0);
        rst_n = 1'b1;
        or8 = 1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            chk("mr_no_stale", ov8, 0);
        end
        chk("mr_in_ready_back", ir8, 1);

        // Randomized traffic on WIDTH=1 and WIDTH=32 against the reference
        for (int cyc = 0; cyc < 1010; cyc++) begin
            if (cyc < 1000) begin
                iv1 = ($urandom_range(0, 9) < 7); or1 = ($urandom_range(0, 9) < 6);
                op1 = 3'($urandom_range(0, 7)); a1 = 1'($urandom); b1 = 1'($urandom);
                iv32 = ($urandom_range(0, 9) < 7); or32 = ($urandom_range(0, 9) < 5);
                op32 = 3'($urandom_range(0, 7)); a32 = $urandom; b32 = $urandom;
            end else begin
                iv1 = 0; or1 = 1; iv32 = 0; or32 = 1;
            end
            #1;
            chk("w1_out_valid", ov1, q1.size() != 0);
            chk("w1_in_ready", ir1, q1.size() < 2);
            if (ov1 && q1.size() != 0) begin
                chk("w1_y", y1, q1[0][63:0]);
                chk("w1_op_err", err1, q1[0][64]);
            end
            if (ov1 && or1 && q1.size() != 0) void'(q1.pop_front());
            if (iv1 && ir1) q1.push_back(lgu_ref(1, op1, a1, b1));

            chk("w32_out_valid", ov32, q32.size() != 0);
            chk("w32_in_ready", ir32, q32.size() < 2);
            if (ov32 && q32.size() != 0) begin
                exp_r = q32[0];
                chk("w32_y", y32, exp_r[63:0]);
                chk("w32_op_err", err32, exp_r[64]);
            end
            if (ov32 && or32 && q32.size() != 0) void'(q32.pop_front());
            if (iv32 && ir32) q32.push_back(lgu_ref(32, op32, a32, b32));
            @(negedge clk);
        end
        chk("w1_final_empty", ov1, 0);
        chk("w32_final_empty", ov32, 0);
        chk("w1_queue_drained", q1.size(), 0);
        chk("w32_queue_drained", q32.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_gate_unit.md
LOGIC_GATE_UNIT -- requirements
Module: logic_gate_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, the operand and result bit width (legal range 1..64).
REQ-002 The module SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n  input  1  reset, asynchronous assert and active-low.
REQ-004 The module SHALL have port in_valid  input  1  the upstream operand set is valid.
REQ-005 The module SHALL have port in_ready  output  1  the unit accepts an operand set this cycle.
REQ-006 The module SHALL have port op  input  3  the operation select, sampled with the operands.
REQ-007 The module SHALL have ports a and b  input  WIDTH  the operands.
REQ-008 The module SHALL have port out_valid  output  1  y and op_err hold a valid result.
REQ-009 The module SHALL have port out_ready  input  1  downstream accepts the result.
REQ-010 The module SHALL have port y  output  WIDTH  the bitwise result.
REQ-011 The module SHALL have port op_err  output  1  the result came from a reserved op code.

Function
REQ-012 The unit SHALL accept an operand set on a cycle with in_valid=1 and in_ready=1.
REQ-013 The unit SHALL evaluate op as follows, bitwise: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT a (b ignored).
REQ-014 For op 111 the unit SHALL produce y=0 with op_err=1; every other op SHALL give op_err=0.
REQ-015 A result SHALL appear at out_valid=1 on the cycle after acceptance when the buffer is empty (latency 1).
REQ-016 The unit SHALL hold results in a 2-entry FIFO skid buffer with occupancy count 0..2.
REQ-017 in_ready SHALL be 1 exactly when count<2; it SHALL be registered and SHALL not depend combinationally on out_ready.
REQ-018 A result SHALL leave the buffer on a cycle with out_valid=1 and out_ready=1; out_valid SHALL be 1 exactly when count>0.
REQ-019 While out_valid=1 and out_ready=0, y and op_err SHALL stay stable.
REQ-020 A push and a pop on the same cycle at count=1 SHALL leave count at 1 and present the new result on the following cycle.
REQ-021 At count=2 no push SHALL occur; a pop SHALL reduce count to 1 and expose the second entry.
REQ-022 Results SHALL leave in acceptance order, with none lost or duplicated.

Reset
REQ-023 When rst_n=0, the unit SHALL immediately clear count to 0 and drive out_valid=0, in_ready=0, y=0 and op_err=0.
REQ-024 On the first clk edge after rst_n rises, in_ready SHALL become 1.
REQ-025 Reset asserted mid-operation SHALL discard all buffered results.

Configuration
REQ-026 Defining LGU_REDUCE_EN SHALL add two outputs, y_any (1 bit, OR-reduction of y) and y_all (1 bit, AND-reduction of y), buffered alongside y, with reset value 0.
REQ-027 Without LGU_REDUCE_EN, y_any and y_all and their storage SHALL be absent.

Structure
REQ-028 The package logic_gate_unit_pkg SHALL hold the op code typedef (7 named codes plus reserved) and the buffer depth constant 2.
REQ-029 The 2-entry buffer SHALL be a sub-module named lgu_skid_buf, parametrised by payload width.

Verification
REQ-030 Bench: reset, then WIDTH=8, a=8'hF0, b=8'h3C, out_ready=1, all ops 000..110 -> y = 30, FC, CC, CF, 03, 33, 0F, one per cycle, each with latency 1.
REQ-031 Bench: op=111, a=8'hFF -> y=8'h00, op_err=1.
REQ-032 Bench: out_ready=0, push 3 sets -> in_ready=0 after 2 accepts, y held stable; then out_ready=1 -> the 2 results drain in order.
REQ-033 Bench: rst_n low for 1 ns mid-stream while count=2 -> out_valid=0 immediately, and no stale result after reset.
REQ-034 Bench: random valid/ready for 1000 cycles, WIDTH=1 and WIDTH=32 -> scoreboard matches every result, in order.
REQ-035 Bench with LGU_REDUCE_EN defined: y=8'h00 -> y_any=0, y_all=0; y=8'hFF -> y_any=1, y_all=1.
